// File: rtl/booth_pkg.sv
// booth_pkg: shared state encodings and default width for the Booth operand sequencer.
//   ST_IDLE..ST_HOLD : 3-bit FSM state encodings
//   BOOTH_WIDTH      : default operand width
package booth_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_M = 3'd1,
      ST_LOAD_Q = 3'd2,
      ST_RUN    = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;
   localparam int BOOTH_WIDTH = 16;
endpackage

// File: rtl/booth_seq_watchdog.sv
// booth_seq_watchdog: counts RUN cycles and flags the cycle on which the timeout is reached.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the counter (asserted on the cycle before RUN is entered)
//   en         : count this cycle (asserted while in RUN)
//   expired    : high during the TIMEOUT_CYCLES-th consecutive RUN cycle
module booth_seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + CNT_W'(1);
   end
   // cnt holds the number of RUN cycles already completed
   assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer: feeds a signed operand pair to a Booth multiplier and returns its product.
//   in_valid/in_ready/in_m/in_q : operand pair input handshake
//   mul_data/mul_start          : drive the multiplier's data_in and start
//   mul_done/mul_a/mul_q        : multiplier completion and product halves
//   out_valid/out_ready         : result handshake; out_prod = {mul_a, mul_q}
//   out_err                     : result aborted by watchdog
//   Optional watchdog enabled by defining BOOTH_SEQ_TIMEOUT_EN.
module booth_operand_sequencer
   import booth_pkg::*;
#(
   parameter int WIDTH          = BOOTH_WIDTH,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_m,
   input  logic [WIDTH-1:0]   in_q,
   output logic [WIDTH-1:0]   mul_data,
   output logic               mul_start,
   input  logic               mul_done,
   input  logic [WIDTH-1:0]   mul_a,
   input  logic [WIDTH-1:0]   mul_q,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic               out_err
);
   state_t state, state_n;
   logic [WIDTH-1:0] m_reg, q_reg;
   logic accept, capture, abort, expired;

   if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cnt_w
      $error("CNT_W too small for TIMEOUT_CYCLES");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_reg <= '0;
         q_reg <= '0;
      end else if (accept) begin
         m_reg <= in_m;
         q_reg <= in_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_prod <= '0;
      else if (capture) out_prod <= {mul_a, mul_q};
      else if (abort) out_prod <= '0;
   end

   // outputs decode straight from state so an async reset drops mul_start at once
   always_comb begin
      state_n   = state;
      accept    = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      in_ready  = state == ST_IDLE;
      out_valid = state == ST_HOLD;
      mul_start = state inside {ST_LOAD_M, ST_LOAD_Q, ST_RUN};
      mul_data  = state == ST_LOAD_M ? m_reg :
                  (state == ST_LOAD_Q || state == ST_RUN) ? q_reg : '0;
      case (state)
         ST_IDLE: if (in_valid) begin
            accept  = 1'b1;
            state_n = ST_LOAD_M;
         end
         ST_LOAD_M: state_n = ST_LOAD_Q;
         ST_LOAD_Q: state_n = ST_RUN;
         ST_RUN: begin
            // a done arriving on the timeout cycle still wins
            capture = mul_done;
            abort   = !mul_done && expired;
            if (mul_done || expired) state_n = ST_HOLD;
         end
         ST_HOLD: if (out_ready) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef BOOTH_SEQ_TIMEOUT_EN
   logic err_reg;
   booth_seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W(CNT_W)
   ) u_watchdog (
      .clk(clk),
      .rst_n(rst_n),
      .clr(state == ST_LOAD_Q),
      .en(state == ST_RUN),
      .expired(expired)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_reg <= 1'b0;
      else if (capture) err_reg <= 1'b0;
      else if (abort) err_reg <= 1'b1;
   end
   assign out_err = err_reg;
`else
   assign expired = 1'b0;
   assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// tb_booth_operand_sequencer: randomized self-checking bench with a behavioural multiplier partner.
module tb_booth_operand_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_m = '0;
   logic [15:0] in_q = '0;
   logic [15:0] mul_data;
   logic        mul_start;
   logic        mul_done;
   logic [15:0] mul_a;
   logic [15:0] mul_q;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_prod;
   logic        out_err;

   int total = 0;
   int bad = 0;

   logic        model_done;
   logic        force_d0 = 1'b0;
   logic        force_d1 = 1'b0;
   int          ph;
   int          cnt;
   int          lat_cfg = 16;
   logic [15:0] op_m, op_q;

   booth_operand_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
      .mul_data(mul_data), .mul_start(mul_start), .mul_done(mul_done),
      .mul_a(mul_a), .mul_q(mul_q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prod(out_prod), .out_err(out_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_prod(input logic [15:0] m, input logic [15:0] q);
      longint p;
      p = longint'($signed(m)) * longint'($signed(q));
      return p[31:0];
   endfunction

   // behavioural multiplier: M on first start cycle, Q on second, done after lat_cfg more cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph <= 0; cnt <= 0; model_done <= 1'b0; op_m <= '0; op_q <= '0;
         mul_a <= '0; mul_q <= '0;
      end else if (!mul_start) begin
         ph <= 0; model_done <= 1'b0;
      end else if (ph == 0) begin
         op_m <= mul_data; ph <= 1;
      end else if (ph == 1) begin
         op_q <= mul_data; cnt <= lat_cfg; ph <= 2;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end else begin
         {mul_a, mul_q} <= ref_prod(op_m, op_q);
         model_done <= 1'b1;
      end
   end

   assign mul_done = (model_done | force_d1) & ~force_d0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] m, input logic [15:0] q);
      int n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      chk("in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_m = m; in_q = q;
      tick();
      in_valid = 1'b0;
      chk("mul_data_m", 64'(mul_data), 64'(m));
      chk("start_m", 64'(mul_start), 64'd1);
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      tick();
      chk("mul_data_q", 64'(mul_data), 64'(q));
   endtask

   task automatic recv(input logic [31:0] exp, input int hold);
      int n = 0;
      while (!mul_done && n < 300) begin tick(); n++; end
      chk("done_seen", 64'(mul_done), 64'd1);
      tick();
      chk("out_valid_lat", 64'(out_valid), 64'd1);
      chk("out_prod", 64'(out_prod), 64'(exp));
      chk("out_err", 64'(out_err), 64'd0);
      chk("start_drop", 64'(mul_start), 64'd0);
      repeat (hold) tick();
      chk("out_prod_hold", 64'(out_prod), 64'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_clr", 64'(out_valid), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [15:0] m, q;
      logic [31:0] exp;
      int n;
      #3;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_start", 64'(mul_start), 64'd0);
      chk("rst_data", 64'(mul_data), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_prod", 64'(out_prod), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      send(16'd15, 16'd10);
      recv(32'd150, 0);
      send(16'hFFF9, 16'd6);
      recv(32'hFFFF_FFD6, 1);
      send(16'h8000, 16'h8000);
      recv(32'h4000_0000, 0);

      // consumer stall: result stable, new operands refused
      send(16'd100, 16'hFFFD);
      exp = ref_prod(16'd100, 16'hFFFD);
      n = 0;
      while (!out_valid && n < 300) begin tick(); n++; end
      chk("stall_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b1; in_m = 16'd7; in_q = 16'd7;
      repeat (20) begin
         tick();
         chk("stall_prod", 64'(out_prod), 64'(exp));
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      chk("stall_valid_end", 64'(out_valid), 64'd1);
      chk("stall_no_start", 64'(mul_start), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall_release", 64'(out_valid), 64'd0);
      chk("stall_idle", 64'(in_ready), 64'd1);

      // reset in the middle of RUN
      send(16'd5, 16'd9);
      repeat (3) tick();
      chk("run_start", 64'(mul_start), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_start", 64'(mul_start), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      send(16'd3, 16'd4);
      recv(32'd12, 0);

      // done pulsed while idle is ignored
      force_d1 = 1'b1;
      repeat (10) tick();
      chk("idle_done_valid", 64'(out_valid), 64'd0);
      chk("idle_done_ready", 64'(in_ready), 64'd1);
      force_d1 = 1'b0;
      tick();

      // multiplier that never finishes
      force_d0 = 1'b1;
      send(16'd11, 16'd13);
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
`ifdef BOOTH_SEQ_TIMEOUT_EN
      chk("to_cycles", 64'(n), 64'd65);
      chk("to_valid", 64'(out_valid), 64'd1);
      chk("to_err", 64'(out_err), 64'd1);
      chk("to_prod", 64'(out_prod), 64'd0);
      chk("to_start", 64'(mul_start), 64'd0);
      force_d0 = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("to_clr", 64'(out_valid), 64'd0);
`else
      chk("hang_valid", 64'(out_valid), 64'd0);
      chk("hang_start", 64'(mul_start), 64'd1);
      force_d0 = 1'b0;
      recv(32'd143, 0);
`endif

      // randomized pairs with varying multiplier latency and consumer delay
      for (int i = 0; i < 25; i++) begin
         m = 16'($urandom);
         q = 16'($urandom);
         lat_cfg = int'($urandom_range(0, 20));
         send(m, q);
         recv(ref_prod(m, q), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
